// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer for the dds phase accumulator.
// Latches a sweep configuration on start, then steps the phase increment
// from incr_start to incr_stop, holding each value for dwell+1 cycles.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i, abort_i         start request (IDLE only) / abort active sweep
//   continuous_i             restart on sweep end instead of finishing
//   phase_init_i             phase loaded at each sweep (re)start
//   incr_start_i/stop_i/step_i  increment sweep range and step
//   dwell_i                  each increment held dwell_i+1 cycles
//   dds_ena_o, dds_phase_o, dds_phase_load_o, dds_phase_incr_o  dds control
//   busy_o                   sweep in progress (LOAD or DWELL)
//   done_o                   one-cycle pulse at normal sweep completion
//
// Build option: DDS_SWEEP_PINGPONG_EN adds a down leg from stop back to start.
module dds_sweep_ctrl #(
    parameter int unsigned PW = 11,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          continuous_i,
    input  logic [PW-1:0] phase_init_i,
    input  logic [PW-1:0] incr_start_i,
    input  logic [PW-1:0] incr_stop_i,
    input  logic [PW-1:0] incr_step_i,
    input  logic [DW-1:0] dwell_i,
    output logic          dds_ena_o,
    output logic [PW-1:0] dds_phase_o,
    output logic          dds_phase_load_o,
    output logic [PW-1:0] dds_phase_incr_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;

    // Latched configuration
    logic          cont_q, cont_d;
    logic [PW-1:0] phase_init_q, phase_init_d;
    logic [PW-1:0] start_q, start_d;
    logic [PW-1:0] stop_q, stop_d;
    logic [PW-1:0] step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;

    // Sweep progress and registered outputs
    logic [DW-1:0] cnt_q, cnt_d;
    logic          ena_q, ena_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          load_q, load_d;
    logic [PW-1:0] incr_q, incr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [PW:0]   sum_up;
    logic [PW-1:0] next_up;
    logic          degen;
    logic          at_end;

`ifdef DDS_SWEEP_PINGPONG_EN
    logic          down_q, down_d;
    logic [PW:0]   diff_dn;
    logic [PW-1:0] next_dn;
`endif

    // Next-increment arithmetic and end-of-sweep detection
    always_comb begin
        sum_up  = {1'b0, incr_q} + {1'b0, step_q};
        next_up = (sum_up >= {1'b0, stop_q}) ? stop_q : sum_up[PW-1:0];
        degen   = (step_q == '0) || (start_q >= stop_q);
`ifdef DDS_SWEEP_PINGPONG_EN
        // Borrow in bit PW means the step undershot zero: clamp at start
        diff_dn = {1'b0, incr_q} - {1'b0, step_q};
        next_dn = (diff_dn[PW] || (diff_dn <= {1'b0, start_q})) ? start_q : diff_dn[PW-1:0];
        at_end  = degen || (down_q && (incr_q == start_q));
`else
        at_end  = degen || (incr_q == stop_q);
`endif
    end

    // Next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        cont_d       = cont_q;
        phase_init_d = phase_init_q;
        start_d      = start_q;
        stop_d       = stop_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;
        ena_d        = 1'b0;
        phase_d      = phase_q;
        load_d       = 1'b0;
        incr_d       = incr_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
        down_d       = down_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    cont_d       = continuous_i;
                    phase_init_d = phase_init_i;
                    start_d      = incr_start_i;
                    stop_d       = incr_stop_i;
                    step_d       = incr_step_i;
                    dwell_d      = dwell_i;
                    state_d      = ST_LOAD;
                    load_d       = 1'b1;
                    phase_d      = phase_init_i;
                    incr_d       = incr_start_i;
                    cnt_d        = dwell_i;
                    ena_d        = 1'b1;
                    busy_d       = 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                    down_d       = 1'b0;
`endif
                end
            end

            // LOAD doubles as the first hold cycle, so it runs the same
            // dwell countdown as DWELL.
            ST_LOAD, ST_DWELL: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    state_d = ST_DWELL;
                    cnt_d   = cnt_q - DW'(1);
                    ena_d   = 1'b1;
                    busy_d  = 1'b1;
                end else if (!at_end) begin
                    state_d = ST_DWELL;
                    cnt_d   = dwell_q;
                    ena_d   = 1'b1;
                    busy_d  = 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                    if (down_q || (incr_q == stop_q)) begin
                        down_d = 1'b1;
                        incr_d = next_dn;
                    end else begin
                        incr_d = next_up;
                    end
`else
                    incr_d  = next_up;
`endif
                end else if (cont_q) begin
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                    phase_d = phase_init_q;
                    incr_d  = start_q;
                    cnt_d   = dwell_q;
                    ena_d   = 1'b1;
                    busy_d  = 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                    down_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, configuration and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cont_q       <= 1'b0;
            phase_init_q <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            ena_q        <= 1'b0;
            phase_q      <= '0;
            load_q       <= 1'b0;
            incr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
            down_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            phase_init_q <= phase_init_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
            ena_q        <= ena_d;
            phase_q      <= phase_d;
            load_q       <= load_d;
            incr_q       <= incr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef DDS_SWEEP_PINGPONG_EN
            down_q       <= down_d;
`endif
        end
    end

    assign dds_ena_o        = ena_q;
    assign dds_phase_o      = phase_q;
    assign dds_phase_load_o = load_q;
    assign dds_phase_incr_o = incr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: directed and randomized sweeps compared
// cycle by cycle against a list-based reference of the expected increments.
module tb_dds_sweep_ctrl;

    localparam int unsigned PW = 11;
    localparam int unsigned DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic          continuous_i;
    logic [PW-1:0] phase_init_i;
    logic [PW-1:0] incr_start_i;
    logic [PW-1:0] incr_stop_i;
    logic [PW-1:0] incr_step_i;
    logic [DW-1:0] dwell_i;
    logic          dds_ena_o;
    logic [PW-1:0] dds_phase_o;
    logic          dds_phase_load_o;
    logic [PW-1:0] dds_phase_incr_o;
    logic          busy_o;
    logic          done_o;

    dds_sweep_ctrl #(.PW(PW), .DW(DW)) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .continuous_i     (continuous_i),
        .phase_init_i     (phase_init_i),
        .incr_start_i     (incr_start_i),
        .incr_stop_i      (incr_stop_i),
        .incr_step_i      (incr_step_i),
        .dwell_i          (dwell_i),
        .dds_ena_o        (dds_ena_o),
        .dds_phase_o      (dds_phase_o),
        .dds_phase_load_o (dds_phase_load_o),
        .dds_phase_incr_o (dds_phase_incr_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk_i = ~clk_i;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_incr = 0;
    int exp_phase = 0;
    int incrs[$];
    int tr_incr[$];
    int tr_load[$];

    task automatic check_val(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string where, input int load, input int ena,
                              input int busy, input int done);
        check_val({where, " load"},  int'(dds_phase_load_o), load);
        check_val({where, " ena"},   int'(dds_ena_o),        ena);
        check_val({where, " busy"},  int'(busy_o),           busy);
        check_val({where, " done"},  int'(done_o),           done);
        check_val({where, " incr"},  int'(dds_phase_incr_o), exp_incr);
        check_val({where, " phase"}, int'(dds_phase_o),      exp_phase);
    endtask

    // Reference: the list of distinct increments visited in one sweep
    task automatic build_incrs(input int s, input int e, input int st);
        int v;
        incrs.delete();
        incrs.push_back(s);
        if (st != 0 && s < e) begin
            v = s;
            while (v != e) begin
                v = (v + st > e) ? e : v + st;
                incrs.push_back(v);
            end
`ifdef DDS_SWEEP_PINGPONG_EN
            while (v != s) begin
                v = (v - st < s) ? s : v - st;
                incrs.push_back(v);
            end
`endif
        end
    endtask

    task automatic scramble_cfg();
        continuous_i = 1'($urandom);
        phase_init_i = PW'($urandom);
        incr_start_i = PW'($urandom);
        incr_stop_i  = PW'($urandom);
        incr_step_i  = PW'($urandom);
        dwell_i      = DW'($urandom);
    endtask

    // One sweep; abort_at < 0 runs to completion (not allowed with cont=1)
    task automatic run_sweep(input int ph, input int s, input int e, input int st,
                             input int dw, input int cont, input int abort_at);
        int n;
        int p;
        continuous_i = cont[0];
        phase_init_i = PW'(ph);
        incr_start_i = PW'(s);
        incr_stop_i  = PW'(e);
        incr_step_i  = PW'(st);
        dwell_i      = DW'(dw);
        abort_i      = 1'b0;
        start_i      = 1'b1;
        @(posedge clk_i); #1;
        scramble_cfg();

        build_incrs(s, e, st);
        tr_incr.delete();
        tr_load.delete();
        for (int k = 0; k < incrs.size(); k++)
            for (int h = 0; h <= dw; h++) begin
                tr_incr.push_back(incrs[k]);
                tr_load.push_back((k == 0 && h == 0) ? 1 : 0);
            end
        p = tr_incr.size();
        exp_phase = ph;
        n = (abort_at >= 0) ? abort_at + 1 : p;

        for (int c = 0; c < n; c++) begin
            exp_incr = tr_incr[c % p];
            check_outs("sweep", tr_load[c % p], 1, 1, 0);
            start_i = (c < n - 1) ? 1'($urandom) : 1'b0;
            abort_i = (abort_at >= 0 && c == n - 1) ? 1'b1 : 1'b0;
            @(posedge clk_i); #1;
            abort_i = 1'b0;
            scramble_cfg();
        end

        if (abort_at >= 0) begin
            check_outs("abort", 0, 0, 0, 0);
        end else begin
            check_outs("done", 0, 0, 0, 1);
            @(posedge clk_i); #1;
            check_outs("idle", 0, 0, 0, 0);
        end
        @(posedge clk_i); #1;
        check_outs("idle2", 0, 0, 0, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s, e, st, dw, cont, ab;
        rst_i   = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        scramble_cfg();
        repeat (2) @(posedge clk_i);
        #1;
        exp_incr  = 0;
        exp_phase = 0;
        check_outs("reset", 0, 0, 0, 0);
        rst_i = 1'b0;

        // start together with abort in IDLE is ignored
        start_i = 1'b1;
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        check_outs("start+abort", 0, 0, 0, 0);
        @(posedge clk_i); #1;
        check_outs("start+abort2", 0, 0, 0, 0);

        run_sweep(77, 100, 130, 10, 3, 0, -1);
        run_sweep(5,  100, 125, 10, 0, 0, -1);
        run_sweep(33, 200, 100, 5,  2, 0, -1);
        run_sweep(34, 200, 100, 0,  2, 0, -1);
        run_sweep(9,  0,   20,  10, 1, 1, 14);
        run_sweep(12, 50,  50,  7,  1, 0, -1);
        run_sweep(1,  2040, 2047, 5, 0, 0, -1);
        run_sweep(2,  10,  90,  30, 2, 0, 4);

        for (int i = 0; i < 30; i++) begin
            s    = int'($urandom_range(0, 2047));
            e    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                               : int'($urandom_range(s, 2047));
            st   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(20, 400));
            dw   = int'($urandom_range(0, 3));
            cont = int'($urandom_range(0, 3) == 0);
            ab   = (cont != 0 || $urandom_range(0, 4) == 0)
                   ? int'($urandom_range(0, dw)) : -1;
            if (cont != 0) ab = ab + int'($urandom_range(0, 60));
            run_sweep(int'($urandom_range(0, 2047)), s, e, st, dw, cont, ab);
        end

        // Reset in the middle of a sweep clears every output
        continuous_i = 1'b0;
        incr_start_i = PW'(300);
        incr_stop_i  = PW'(900);
        incr_step_i  = PW'(50);
        dwell_i      = DW'(2);
        phase_init_i = PW'(123);
        start_i      = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        exp_incr  = 0;
        exp_phase = 0;
        check_outs("midreset", 0, 0, 0, 0);
        @(posedge clk_i); #1;
        check_outs("midreset2", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
